// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared constants and types for the bit-serial adder/subtractor.
//   WIDTH   : operand/result width
//   OP_*    : encodings of the op input
//   state_t : controller states
package serial_addsub_pkg;

    localparam int WIDTH = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// full_adder_1b
//   Single-bit full adder; the only arithmetic cell of serial_addsub.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial add/subtract, LSB first, one bit per clock through a single
//   full adder. Subtraction is A + ~B + 1, so carry=1 means "no borrow".
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : request, sampled with op/a/b; ignored while busy
//   op       : 0 = A+B, 1 = A-B
//   a, b     : operands
//   busy     : high while bits are being processed (state RUN)
//   done     : one-cycle completion pulse (state DONE)
//   result   : sum or difference, updated only on completion
//   carry    : carry out of the MSB
//   overflow : signed overflow (carry into MSB xor carry out of MSB)
//   zero     : result == 0
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one bit per cycle, WIDTH cycles
//   DONE  | completion cycle; start here chains straight into RUN
module serial_addsub #(
    parameter int WIDTH = serial_addsub_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    import serial_addsub_pkg::*;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_nx;

    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c_reg;
    logic [WIDTH-2:0] res_sr;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] res_full;

    full_adder_1b u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Final sum: the bit being produced now on top of the seven already shifted in.
    assign res_full = {fa_s, res_sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last_bit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    last_bit = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            c_reg    <= 1'b0;
            res_sr   <= '0;
            cnt      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            cnt    <= '0;
            res_sr <= '0;
            // Subtract is folded into the load: complement B and seed carry with 1.
            if (op == OP_SUB) begin
                b_sh  <= ~b;
                c_reg <= 1'b1;
            end else begin
                b_sh  <= b;
                c_reg <= 1'b0;
            end
        end else if (state == RUN) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            c_reg  <= fa_cout;
            res_sr <= {fa_s, res_sr[WIDTH-2:1]};
            cnt    <= last_bit ? '0 : cnt + 1'b1;
            if (last_bit) begin
                result   <= res_full;
                carry    <= fa_cout;
                // c_reg still holds the carry into the MSB during the last bit.
                overflow <= c_reg ^ fa_cout;
                zero     <= (res_full == '0);
            end
        end
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; only 8 is required to be supported.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request; sampled on the rising edge of clk.
REQ-006 Port: op  input  1  0 = A+B, 1 = A-B; sampled together with start.
REQ-007 Port: a  input  8  operand A; sampled together with start.
REQ-008 Port: b  input  8  operand B; sampled together with start.
REQ-009 Port: busy  output  1  high while bits are being processed.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: result  output  8  sum or difference.
REQ-012 Port: carry  output  1  carry-out; for subtract, 1 = no borrow.
REQ-013 Port: overflow  output  1  signed overflow.
REQ-014 Port: zero  output  1  result == 0.

Function
REQ-015 The block SHALL compute bit-serially, LSB first, one bit per clock, using one full-adder cell.
REQ-016 The FSM SHALL have exactly 3 states: IDLE, RUN and DONE.
REQ-017 State transitions SHALL be as follows.
- IDLE --start--> RUN
- RUN --after the 8th bit--> DONE
- DONE --start--> RUN
- DONE --no start--> IDLE
REQ-018 On accepting start, the block SHALL capture a and op, and load the B register as follows.
- op=0: B register = b, carry register = 0
- op=1: B register = ones-complement of b, carry register = 1
REQ-019 A 3-bit counter SHALL index the bit position, cleared on accept, incremented each RUN cycle, wrapping 7->0 on the DONE transition.
REQ-020 Timing SHALL be as follows.
- Start accepted at edge 0.
- Bits 0..7 are produced at edges 1..8.
- done=1 for exactly the cycle after edge 8.
- Total latency from accept to done is 9 cycles.
REQ-021 busy SHALL be 1 exactly while state==RUN.
REQ-022 start SHALL be ignored while busy; operand inputs are don't-care then.
REQ-023 result, carry, overflow and zero SHALL update only at edge 8 and hold until the next completion.
REQ-024 The output flags SHALL be defined as follows.
- carry = carry out of bit 7
- overflow = carry into bit 7 XOR carry out of bit 7
- zero = (result == 8'h00)
REQ-025 Arithmetic SHALL be modulo 2^8 with no saturation.

Reset
REQ-026 On rst_n=0, the block SHALL immediately set the following, independent of clk.
- state = IDLE, counter = 0
- busy = 0, done = 0
- result = 8'h00, carry = 0, overflow = 0, zero = 0
- operand and carry registers cleared
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; flags SHALL take their reset values.
REQ-028 The first start after rst_n deasserts SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-029 Package serial_addsub_pkg SHALL hold the following.
- WIDTH constant
- state enum (IDLE, RUN, DONE)
- op encodings OP_ADD=0, OP_SUB=1
REQ-030 The only sub-module SHALL be full_adder_1b (inputs a, b, cin; outputs s, cout), instantiated once.
REQ-031 Operand registers SHALL shift right each RUN cycle; result SHALL be assembled in a shift register and copied to the output register at edge 8.

Verification
REQ-032 Add: op=0, a=8'h35, b=8'h1A -> at the done cycle, 9 cycles after accept: result=8'h4F, carry=0, overflow=0, zero=0.
REQ-033 Subtract equal operands: op=1, a=8'h10, b=8'h10 -> result=8'h00, carry=1, zero=1, overflow=0.
REQ-034 Borrow and signed overflow: op=1, a=8'h00, b=8'h01 -> result=8'hFF, carry=0, overflow=0; then op=0, a=8'h7F, b=8'h01 -> result=8'h80, overflow=1, carry=0.
REQ-035 Ignore while busy: start with a=8'h02, b=8'h03 (add), re-pulse start with a=8'hFF at cycle 4 -> result=8'h05, a single done pulse, busy=1 for exactly 8 cycles.
REQ-036 Back-to-back: start asserted during the DONE cycle -> the new operation is accepted with no IDLE cycle; its done arrives 9 cycles later.
REQ-037 Reset mid-run: rst_n low at cycle 5 of RUN -> all outputs 0 immediately, no done pulse; the next start completes normally.
